video_writer: RTL

- CPU-side write port for the video tile renderer's picture tables: palette definitions, tile bitmaps, palette map and tile map.
- Accepts word writes from the c16 bus through a valid/ready handshake and buffers them in a small FIFO.
- Decodes each address into a table select and an index, and commits one table write per cycle, only while the renderer's blanking permit (`commit_en`) is high.
- Also runs a hardware clear sweep that zeroes every table.

---
 rtl/video_pkg.sv | 93 +++++++++
 rtl/video_wfifo.sv | 52 +++++
 rtl/video_writer.sv | 118 +++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the tile renderer's picture tables and the CPU-side writer.
// Holds the table selects, region bounds, table sizes, writer FSM states and address decode.
package video_pkg;

    localparam logic [1:0] SEL_PALDEF  = 2'd0;
    localparam logic [1:0] SEL_TILEDEF = 2'd1;
    localparam logic [1:0] SEL_PALMAP  = 2'd2;
    localparam logic [1:0] SEL_TILEMAP = 2'd3;

    localparam logic [15:0] PALDEF_BASE  = 16'h0000;
    localparam logic [15:0] TILEDEF_BASE = 16'h0400;
    localparam logic [15:0] PALMAP_BASE  = 16'h0800;
    localparam logic [15:0] TILEMAP_BASE = 16'h0C00;
    localparam logic [15:0] CLEAR_ADDR   = 16'hFFFF;

    localparam int PALDEF_SIZE  = 16;
    localparam int TILEDEF_SIZE = 64 * 16;
    localparam int PALMAP_SIZE  = 300;
    localparam int TILEMAP_SIZE = 300;

    typedef logic [2:0] wr_state_t;
    localparam wr_state_t ST_IDLE     = 3'd0;
    localparam wr_state_t ST_CLR_PAL  = 3'd1;
    localparam wr_state_t ST_CLR_TILE = 3'd2;
    localparam wr_state_t ST_CLR_PMAP = 3'd3;
    localparam wr_state_t ST_CLR_TMAP = 3'd4;

    typedef struct packed {
        logic        ok;
        logic        clear;
        logic [1:0]  sel;
        logic [9:0]  addr;
        logic [15:0] data;
    } wr_decode_t;

    // Map, tile and palmap bases are 1 KiB aligned, so the index is simply a[9:0].
    function automatic wr_decode_t decode_write(input logic [15:0] a, input logic [15:0] d);
        wr_decode_t r;
        r = '0;
        if (a == CLEAR_ADDR) begin
            r.clear = 1'b1;
        end else if (a[15:4] == PALDEF_BASE[15:4]) begin
            r.ok   = 1'b1;
            r.sel  = SEL_PALDEF;
            r.addr = {6'd0, a[3:0]};
            r.data = {4'd0, d[11:0]};
        end else if (a[15:10] == TILEDEF_BASE[15:10]) begin
            r.ok   = 1'b1;
            r.sel  = SEL_TILEDEF;
            r.addr = a[9:0];
            r.data = d;
        end else if (a[15:10] == PALMAP_BASE[15:10] && a[9:0] < 10'(PALMAP_SIZE)) begin
            r.ok   = 1'b1;
            r.sel  = SEL_PALMAP;
            r.addr = a[9:0];
            r.data = {8'd0, d[7:0]};
        end else if (a[15:10] == TILEMAP_BASE[15:10] && a[9:0] < 10'(TILEMAP_SIZE)) begin
            r.ok   = 1'b1;
            r.sel  = SEL_TILEMAP;
            r.addr = a[9:0];
            r.data = {10'd0, d[5:0]};
        end
        return r;
    endfunction

    function automatic logic [1:0] clr_sel(input wr_state_t s);
        case (s)
            ST_CLR_TILE: return SEL_TILEDEF;
            ST_CLR_PMAP: return SEL_PALMAP;
            ST_CLR_TMAP: return SEL_TILEMAP;
            default:     return SEL_PALDEF;
        endcase
    endfunction

    function automatic logic [9:0] clr_last(input wr_state_t s);
        case (s)
            ST_CLR_TILE: return 10'(TILEDEF_SIZE - 1);
            ST_CLR_PMAP: return 10'(PALMAP_SIZE - 1);
            ST_CLR_TMAP: return 10'(TILEMAP_SIZE - 1);
            default:     return 10'(PALDEF_SIZE - 1);
        endcase
    endfunction

    function automatic wr_state_t clr_next(input wr_state_t s);
        case (s)
            ST_CLR_PAL:  return ST_CLR_TILE;
            ST_CLR_TILE: return ST_CLR_PMAP;
            ST_CLR_PMAP: return ST_CLR_TMAP;
            default:     return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/video_wfifo.sv
// Small synchronous FIFO buffering CPU writes (address and data) ahead of the table commit.
// The head entry is visible combinationally so a pop and its table strobe share one edge.
module video_wfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/video_writer.sv
// CPU write port for the picture tables: buffers bus writes, decodes them into table
// writes committed only during blanking, and runs the hardware clear sweep.
module video_writer
    import video_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_data,
    input  logic        commit_en,
    output logic        wr_en,
    output logic [1:0]  wr_sel,
    output logic [9:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        busy,
    output logic        err,
    input  logic        err_clr
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   head;
    logic          fifo_full, fifo_empty, push, pop;
    logic [CW-1:0] fifo_count;
    wr_decode_t    dec;

    wr_state_t   state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        wr_en_q, wr_en_d;
    logic [1:0]  wr_sel_q, wr_sel_d;
    logic [9:0]  wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        err_q, err_d;

    assign cpu_ready = !fifo_full;
    assign push      = cpu_valid && cpu_ready;
    assign pop       = (state_q == ST_IDLE) && !fifo_empty && commit_en;
    assign dec       = decode_write(head[31:16], head[15:0]);

    video_wfifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (push),
        .din_i   ({cpu_addr, cpu_data}),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_sel_d  = wr_sel_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        // A new error in the same cycle as err_clr must win.
        err_d     = err_q && !err_clr;
        if (state_q == ST_IDLE) begin
            if (pop) begin
                if (dec.clear) begin
                    state_d = ST_CLR_PAL;
                    cnt_d   = '0;
                end else if (dec.ok) begin
                    wr_en_d   = 1'b1;
                    wr_sel_d  = dec.sel;
                    wr_addr_d = dec.addr;
                    wr_data_d = dec.data;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (commit_en) begin
            wr_en_d   = 1'b1;
            wr_sel_d  = clr_sel(state_q);
            wr_addr_d = cnt_q;
            wr_data_d = '0;
            if (cnt_q == clr_last(state_q)) begin
                cnt_d   = '0;
                state_d = clr_next(state_q);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_sel  = wr_sel_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign err     = err_q;
    assign busy    = (fifo_count != '0) || (state_q != ST_IDLE);
endmodule
